// File: rtl/secded_shift_reg.sv
// secded_shift_reg: universal shift register whose storage is protected per
// 4-bit block by an extended Hamming (8,4) SECDED code, with an on-demand
// background scrubber that repairs correctable blocks in place.
// Optional feature macro: SECDED_ERR_CNT_EN (saturating corrected-error counter).
module secded_shift_reg #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             scrub_req,
    input  logic             ue_clr,
    output logic             serial_out,
    output logic [WIDTH-1:0] parallel_out,
    output logic             busy,
    output logic             ce_pulse,
    output logic             ue_flag,
    output logic [CNT_W-1:0] ce_count
);

    localparam int NB = WIDTH / 4;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    // Check nibble layout per block: {p3, p2, p1, p0}
    function automatic logic [3:0] f_chk(input logic [3:0] d);
        logic p1, p2, p3, p0;
        p1 = d[0] ^ d[2] ^ d[3];
        p2 = d[0] ^ d[1] ^ d[3];
        p3 = d[0] ^ d[1] ^ d[2];
        p0 = (^d) ^ p1 ^ p2 ^ p3;
        return {p3, p2, p1, p0};
    endfunction

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_chk;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    w_idx_nxt;
    logic             r_ue_flag;

    logic [WIDTH-1:0] w_view;
    logic [WIDTH-1:0] w_vchk;
    logic [NB-1:0]    w_ce;
    logic [NB-1:0]    w_ue;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_next_chk;
    logic             w_idx_last;
    logic             w_wr_en;
    logic             w_ue_set;

    // Decode every block: syndrome, overall parity, class and corrected bits
    always_comb begin
        w_view = '0;
        w_vchk = '0;
        w_ce   = '0;
        w_ue   = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            logic [3:0] d;
            logic [3:0] c;
            logic [2:0] s;
            logic       o;
            d = r_data[4*b +: 4];
            c = r_chk[4*b +: 4];
            s = {c[3] ^ d[2] ^ d[1] ^ d[0],
                 c[2] ^ d[3] ^ d[1] ^ d[0],
                 c[1] ^ d[3] ^ d[2] ^ d[0]};
            o = ^{c, d};
            w_ce[b] = o;
            w_ue[b] = ~o & (s != 3'b000);
            if (o) begin
                case (s)
                    3'b101:  d[2] = ~d[2];
                    3'b111:  d[0] = ~d[0];
                    3'b011:  d[3] = ~d[3];
                    3'b110:  d[1] = ~d[1];
                    3'b001:  c[1] = ~c[1];
                    3'b010:  c[2] = ~c[2];
                    3'b100:  c[3] = ~c[3];
                    default: c[0] = ~c[0];
                endcase
            end
            w_view[4*b +: 4] = d;
            w_vchk[4*b +: 4] = c;
        end
    end

    // Next stored word for an enabled cycle, with freshly encoded check bits
    always_comb begin
        case (mode)
            2'b00:   w_next = {serial_in, w_view[WIDTH-1:1]};
            2'b01:   w_next = {w_view[WIDTH-2:0], serial_in};
            2'b10:   w_next = load ? parallel_in : {1'b0, w_view[WIDTH-1:1]};
            default: w_next = load ? parallel_in : w_view;
        endcase
        w_next_chk = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            w_next_chk[4*b +: 4] = f_chk(w_next[4*b +: 4]);
        end
    end

    assign w_idx_last = (r_idx == IW'(NB - 1));

    // Scrub FSM state and block index register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Scrub FSM next state: any enabled cycle aborts a pass back to IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (enable) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (scrub_req) begin
                        w_state_nxt = S_SCAN;
                        w_idx_nxt   = '0;
                    end
                end
                S_SCAN, S_WRITE: begin
                    if (r_state == S_SCAN && w_ce[r_idx]) begin
                        w_state_nxt = S_WRITE;
                    end else if (w_idx_last) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = S_SCAN;
                        w_idx_nxt   = r_idx + IW'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // Scrub FSM outputs: busy, write strobe, error event strobes
    always_comb begin
        busy     = (r_state != S_IDLE);
        w_wr_en  = (r_state == S_WRITE) && !enable;
        ce_pulse = enable ? (|w_ce) : (r_state == S_WRITE);
        w_ue_set = enable ? (|w_ue) : ((r_state == S_SCAN) && w_ue[r_idx]);
    end

    // Storage: enabled shift/load wins over a pending scrub write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_chk  <= '0;
        end else if (enable) begin
            r_data <= w_next;
            r_chk  <= w_next_chk;
        end else if (w_wr_en) begin
            r_data[{r_idx, 2'b00} +: 4] <= w_view[{r_idx, 2'b00} +: 4];
            r_chk[{r_idx, 2'b00} +: 4]  <= w_vchk[{r_idx, 2'b00} +: 4];
        end
    end

    // Sticky uncorrectable flag; a new set beats a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ue_flag <= 1'b0;
        end else if (w_ue_set) begin
            r_ue_flag <= 1'b1;
        end else if (ue_clr) begin
            r_ue_flag <= 1'b0;
        end
    end

    assign ue_flag      = r_ue_flag;
    assign parallel_out = w_view;
    assign serial_out   = mode[0] ? w_view[WIDTH-1] : w_view[0];

`ifdef SECDED_ERR_CNT_EN
    logic [CNT_W-1:0] r_ce_count;

    // Saturating count of corrected-error events
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ce_count <= '0;
        end else if (ce_pulse && (r_ce_count != '1)) begin
            r_ce_count <= r_ce_count + CNT_W'(1);
        end
    end

    assign ce_count = r_ce_count;
`else
    assign ce_count = '0;
`endif

endmodule

// File: tb/tb_secded_shift_reg.sv
// tb_secded_shift_reg: directed bench for secded_shift_reg (WIDTH=16, CNT_W=2).
// The reference model decodes each block by nearest-codeword search.
module tb_secded_shift_reg;

    localparam int W  = 16;
    localparam int NB = 4;
    localparam int CW = 2;
`ifdef SECDED_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          load = 1'b0;
    logic          serial_in = 1'b0;
    logic [W-1:0]  parallel_in = '0;
    logic          scrub_req = 1'b0;
    logic          ue_clr = 1'b0;
    logic          serial_out;
    logic [W-1:0]  parallel_out;
    logic          busy;
    logic          ce_pulse;
    logic          ue_flag;
    logic [CW-1:0] ce_count;

    secded_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .load(load),
        .serial_in(serial_in), .parallel_in(parallel_in), .scrub_req(scrub_req),
        .ue_clr(ue_clr), .serial_out(serial_out), .parallel_out(parallel_out),
        .busy(busy), .ce_pulse(ce_pulse), .ue_flag(ue_flag), .ce_count(ce_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit run = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Code byte per block: {p3, p2, p1, p0, d3, d2, d1, d0}
    logic [7:0] m_code [NB] = '{default: 8'h00};
    int         m_st  = 0;   // 0 idle, 1 scanning, 2 writing
    int         m_idx = 0;
    bit         m_ue  = 1'b0;
    int         m_cnt = 0;

    function automatic logic [7:0] enc(input logic [3:0] d);
        logic p1, p2, p3, p0;
        p1 = d[0] ^ d[2] ^ d[3];
        p2 = d[0] ^ d[1] ^ d[3];
        p3 = d[0] ^ d[1] ^ d[2];
        p0 = d[0] ^ d[1] ^ d[2] ^ d[3] ^ p1 ^ p2 ^ p3;
        return {p3, p2, p1, p0, d};
    endfunction

    // 0 clean, 1 one bit from a codeword, 2 otherwise (raw data returned)
    function automatic int classify(input logic [7:0] code, output logic [3:0] d);
        d = code[3:0];
        for (int c = 0; c < 16; c++) begin
            if (enc(4'(c)) == code) begin
                d = 4'(c);
                return 0;
            end
        end
        for (int c = 0; c < 16; c++) begin
            if ($countones(enc(4'(c)) ^ code) == 1) begin
                d = 4'(c);
                return 1;
            end
        end
        return 2;
    endfunction

    function automatic logic [W-1:0] mview();
        logic [W-1:0] v;
        logic [3:0]   d;
        v = '0;
        for (int b = 0; b < NB; b++) begin
            void'(classify(m_code[b], d));
            v[4*b +: 4] = d;
        end
        return v;
    endfunction

    function automatic int count_class(input int k);
        logic [3:0] d;
        int n;
        n = 0;
        for (int b = 0; b < NB; b++) begin
            if (classify(m_code[b], d) == k) n++;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin : model
        logic [W-1:0] v, nv;
        logic [3:0]   dd;
        int           ic;
        bit           ce, us;
        if (!rst) begin
            for (int b = 0; b < NB; b++) m_code[b] = 8'h00;
            m_st = 0; m_idx = 0; m_ue = 1'b0; m_cnt = 0;
        end else begin
            v  = mview();
            ic = classify(m_code[m_idx], dd);
            ce = enable ? (count_class(1) > 0) : (m_st == 2);
            us = enable ? (count_class(2) > 0) : (m_st == 1 && ic == 2);
            if (enable) begin
                case (mode)
                    2'd0:    nv = {serial_in, v[W-1:1]};
                    2'd1:    nv = {v[W-2:0], serial_in};
                    2'd2:    nv = load ? parallel_in : (v >> 1);
                    default: nv = load ? parallel_in : v;
                endcase
                for (int b = 0; b < NB; b++) m_code[b] = enc(nv[4*b +: 4]);
                m_st = 0; m_idx = 0;
            end else begin
                if (m_st == 0) begin
                    if (scrub_req) begin m_st = 1; m_idx = 0; end
                end else if (m_st == 1 && ic == 1) begin
                    m_st = 2;
                end else begin
                    if (m_st == 2) m_code[m_idx] = enc(dd);
                    if (m_idx == NB - 1) begin m_st = 0; m_idx = 0; end
                    else begin m_st = 1; m_idx++; end
                end
            end
            m_ue = us | (m_ue & ~ue_clr);
            if (CNT_EN && ce && m_cnt < 3) m_cnt++;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin : compare
        logic [W-1:0] v;
        if (run) begin
            v = mview();
            chk("parallel_out", 32'(parallel_out), 32'(v));
            chk("serial_out", 32'(serial_out), 32'(mode[0] ? v[W-1] : v[0]));
            chk("busy", 32'(busy), 32'(m_st != 0));
            chk("ce_pulse", 32'(ce_pulse), 32'(enable ? (count_class(1) > 0) : (m_st == 2)));
            chk("ue_flag", 32'(ue_flag), 32'(m_ue));
            chk("ce_count", 32'(ce_count), 32'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    logic [W-1:0] f_val;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Flip one stored bit of block blk (code bit 0-3 data, 4-7 check)
    task automatic flip(input int blk, input int cbit);
        #1;
        if (cbit < 4) begin
            f_val = dut.r_data ^ (W'(1) << (4*blk + cbit));
            force dut.r_data = f_val;
            #1;
            release dut.r_data;
        end else begin
            f_val = dut.r_chk ^ (W'(1) << (4*blk + cbit - 4));
            force dut.r_chk = f_val;
            #1;
            release dut.r_chk;
        end
        m_code[blk] = m_code[blk] ^ (8'h01 << cbit);
    endtask

    // Count busy / ce_pulse cycles of one scrub pass, bounded
    task automatic scrub(output int nb, output int nce);
        nb = 0; nce = 0;
        scrub_req = 1'b1;
        tick();
        scrub_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
            nb++;
            if (ce_pulse) nce++;
        end
        tick();
    endtask

    task automatic load_word(input logic [W-1:0] val);
        mode = 2'b11; load = 1'b1; parallel_in = val; enable = 1'b1;
        tick();
        enable = 1'b0; load = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int nb, nce;
        run = 1'b1;
        rst = 1'b0;
        repeat (2) tick();
        chk("reset parallel_out", 32'(parallel_out), 32'h0);
        chk("reset serial_out", 32'(serial_out), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset ue_flag", 32'(ue_flag), 32'h0);
        chk("reset ce_count", 32'(ce_count), 32'h0);
        rst = 1'b1;
        tick();

        // PIPO load
        load_word(16'hA5C3);
        settle();
        chk("load value", 32'(parallel_out), 32'hA5C3);
        chk("load ce_pulse", 32'(ce_pulse), 32'h0);
        chk("load ue_flag", 32'(ue_flag), 32'h0);
        chk("load check bits", 32'(dut.r_chk), 32'hA5C3);
        chk("model view", 32'(mview()), 32'hA5C3);

        // single-bit error scrubbed in place
        flip(1, 2);
        settle();
        chk("corrected view", 32'(parallel_out), 32'hA5C3);
        scrub(nb, nce);
        chk("ce scrub busy cycles", 32'(nb), 32'd5);
        chk("ce scrub pulses", 32'(nce), 32'd1);
        chk("ce scrub count", 32'(ce_count), CNT_EN ? 32'd1 : 32'd0);
        chk("repaired data", 32'(dut.r_data), 32'hA5C3);
        chk("repaired check", 32'(dut.r_chk), 32'hA5C3);

        // double-bit error: flagged, left alone
        flip(0, 0);
        flip(0, 1);
        settle();
        chk("ue raw view", 32'(parallel_out), 32'hA5C0);
        scrub(nb, nce);
        chk("ue scrub busy cycles", 32'(nb), 32'd4);
        chk("ue scrub pulses", 32'(nce), 32'd0);
        chk("ue flag set", 32'(ue_flag), 32'h1);
        chk("ue data untouched", 32'(dut.r_data), 32'hA5C0);
        ue_clr = 1'b1;
        tick();
        ue_clr = 1'b0;
        settle();
        chk("ue cleared", 32'(ue_flag), 32'h0);

        // set beats clear in the same cycle
        ue_clr = 1'b1;
        load_word(16'h0000);
        ue_clr = 1'b0;
        settle();
        chk("ue set wins", 32'(ue_flag), 32'h1);
        ue_clr = 1'b1;
        tick();
        ue_clr = 1'b0;
        settle();
        chk("ue cleared again", 32'(ue_flag), 32'h0);

        // SISO right filling with ones
        mode = 2'b00; serial_in = 1'b1; enable = 1'b1;
        repeat (16) tick();
        enable = 1'b0; serial_in = 1'b0;
        settle();
        chk("siso right fill", 32'(parallel_out), 32'hFFFF);
        chk("siso right serial_out", 32'(serial_out), 32'h1);

        // SISO left
        load_word(16'h8001);
        mode = 2'b01; serial_in = 1'b1; enable = 1'b1;
        tick();
        serial_in = 1'b0;
        tick();
        enable = 1'b0;
        settle();
        chk("siso left", 32'(parallel_out), 32'h0006);
        chk("siso left serial_out", 32'(serial_out), 32'h0);

        // PISO
        mode = 2'b10; load = 1'b1; parallel_in = 16'h00F0; enable = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        enable = 1'b0;
        settle();
        chk("piso shift", 32'(parallel_out), 32'h000F);
        chk("piso serial_out", 32'(serial_out), 32'h1);

        // shift aborts a scrub in its second SCAN cycle
        load_word(16'h1234);
        flip(2, 5);
        settle();
        chk("p1 error view", 32'(parallel_out), 32'h1234);
        scrub_req = 1'b1;
        tick();
        scrub_req = 1'b0;
        tick();
        mode = 2'b01; serial_in = 1'b1; enable = 1'b1;
        settle();
        chk("abort in scan", 32'(busy), 32'h1);
        tick();
        enable = 1'b0; serial_in = 1'b0;
        settle();
        chk("abort busy", 32'(busy), 32'h0);
        chk("abort shift", 32'(parallel_out), 32'h2469);
        chk("abort check bits", 32'(dut.r_chk[11:8]), 32'hB);
        repeat (3) tick();

        // enabled-cycle corrections drive the counter to saturation
        for (int k = 0; k < 5; k++) begin
            flip(k % 4, k % 8);
            mode = 2'b11; load = 1'b0; enable = 1'b1;
            tick();
            enable = 1'b0;
        end
        settle();
        chk("ce_count saturated", 32'(ce_count), CNT_EN ? 32'd3 : 32'd0);

        // reset in mid-scrub abandons the pass
        flip(3, 2);
        scrub_req = 1'b1;
        tick();
        scrub_req = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        settle();
        chk("mid-scrub reset busy", 32'(busy), 32'h0);
        chk("mid-scrub reset data", 32'(dut.r_data), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        settle();
        chk("post reset view", 32'(parallel_out), 32'h0);

        tick();
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
